// File: rtl/reg_file_sb.sv
// Register file with per-register pending (scoreboard) bits, write-back bypass
// and a registered population count of outstanding destinations.
module reg_file_sb #(
  parameter int NREG   = 32,
  parameter int DATA_W = 32,
  parameter int NRD    = 2,
  parameter int NWR    = 1,
  localparam int AW    = $clog2(NREG),
  localparam int CW    = $clog2(NREG + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NRD-1:0][AW-1:0]        rd_addr,
  output logic [NRD-1:0][DATA_W-1:0]    rd_data,
  output logic [NRD-1:0]                rd_ready,
  input  logic [NWR-1:0]                wr_en,
  input  logic [NWR-1:0][AW-1:0]        wr_addr,
  input  logic [NWR-1:0][DATA_W-1:0]    wr_data,
  input  logic                          iss_en,
  input  logic [AW-1:0]                 iss_addr,
  output logic [CW-1:0]                 pend_cnt,
  output logic                          any_pend
);

  logic [DATA_W-1:0] r_regs [NREG];
  logic [NREG-1:0]   r_pend;
  logic [CW-1:0]     r_pend_cnt;
  logic              r_any_pend;

  logic [NREG-1:0]   w_pend_nxt;
  logic [CW-1:0]     w_pend_cnt_nxt;
  logic [NRD-1:0]    w_hit;

  function automatic logic [CW-1:0] popcount(input logic [NREG-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < NREG; i++) c = c + CW'(v[i]);
    return c;
  endfunction

  // Clear on write-back first, then set on issue, so a same-cycle issue wins.
  always_comb begin
    w_pend_nxt = r_pend;
    for (int w = 0; w < NWR; w++) begin
      if (wr_en[w] && (wr_addr[w] != '0)) w_pend_nxt[wr_addr[w]] = 1'b0;
    end
    if (iss_en && (iss_addr != '0)) w_pend_nxt[iss_addr] = 1'b1;
    w_pend_cnt_nxt = popcount(w_pend_nxt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
      r_pend     <= '0;
      r_pend_cnt <= '0;
      r_any_pend <= 1'b0;
    end else begin
      // Later ports overwrite earlier ones, giving the higher index priority.
      for (int w = 0; w < NWR; w++) begin
        if (wr_en[w] && (wr_addr[w] != '0)) r_regs[wr_addr[w]] <= wr_data[w];
      end
      r_pend     <= w_pend_nxt;
      r_pend_cnt <= w_pend_cnt_nxt;
      r_any_pend <= (w_pend_cnt_nxt != '0);
    end
  end

  always_comb begin
    w_hit = '0;
    for (int p = 0; p < NRD; p++) begin
      rd_data[p]  = r_regs[rd_addr[p]];
      rd_ready[p] = ~r_pend[rd_addr[p]];
      for (int w = 0; w < NWR; w++) begin
        if (!rst && wr_en[w] && (wr_addr[w] == rd_addr[p])) begin
          rd_data[p] = wr_data[w];
          w_hit[p]   = 1'b1;
        end
      end
      if (w_hit[p]) rd_ready[p] = ~(iss_en && (iss_addr == rd_addr[p]));
      if (rd_addr[p] == '0) begin
        rd_data[p]  = '0;
        rd_ready[p] = 1'b1;
      end
    end
  end

  assign pend_cnt = r_pend_cnt;
  assign any_pend = r_any_pend;

endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb: driver pushes model expectations per cycle,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_reg_file_sb;
  localparam int NREG   = 32;
  localparam int DATA_W = 32;
  localparam int NRD    = 2;
  localparam int NWR    = 2;
  localparam int AW     = $clog2(NREG);
  localparam int CW     = $clog2(NREG + 1);

  logic                       clk = 1'b0;
  logic                       rst;
  logic [NRD-1:0][AW-1:0]     rd_addr;
  logic [NRD-1:0][DATA_W-1:0] rd_data;
  logic [NRD-1:0]             rd_ready;
  logic [NWR-1:0]             wr_en;
  logic [NWR-1:0][AW-1:0]     wr_addr;
  logic [NWR-1:0][DATA_W-1:0] wr_data;
  logic                       iss_en;
  logic [AW-1:0]              iss_addr;
  logic [CW-1:0]              pend_cnt;
  logic                       any_pend;

  reg_file_sb #(.NREG(NREG), .DATA_W(DATA_W), .NRD(NRD), .NWR(NWR)) dut (
    .clk(clk), .rst(rst),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_ready(rd_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr),
    .pend_cnt(pend_cnt), .any_pend(any_pend)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NRD-1:0][DATA_W-1:0] data;
    logic [NRD-1:0]             rdy;
    logic [CW-1:0]              cnt;
    logic                       anyp;
    int                         tag;
  } exp_t;

  exp_t            exp_q[$];
  logic [DATA_W-1:0] mdl_reg [NREG];
  bit              mdl_pend [NREG];
  int checks = 0, errors = 0, pushed = 0, popped = 0;

  function automatic int pend_count();
    int n = 0;
    for (int i = 0; i < NREG; i++) if (mdl_pend[i]) n++;
    return n;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NREG; i++) begin
      mdl_reg[i]  = '0;
      mdl_pend[i] = 1'b0;
    end
  endtask

  task automatic idle();
    wr_en  = '0;
    iss_en = 1'b0;
    for (int w = 0; w < NWR; w++) begin
      wr_addr[w] = AW'($urandom_range(0, NREG - 1));
      wr_data[w] = $urandom;
    end
    iss_addr = AW'($urandom_range(0, NREG - 1));
  endtask

  // One clock cycle: inputs are already set; rst is applied here, mid-cycle.
  task automatic step(input logic r, input int tag);
    exp_t e;
    int   a;
    bit   hit;
    rst = r;
    for (int p = 0; p < NRD; p++) begin
      a = int'(rd_addr[p]);
      hit = 1'b0;
      e.data[p] = '0;
      e.rdy[p]  = 1'b1;
      if (!r && a != 0) begin
        for (int w = 0; w < NWR; w++)
          if (wr_en[w] && int'(wr_addr[w]) == a) begin
            e.data[p] = wr_data[w];
            hit = 1'b1;
          end
        if (hit) e.rdy[p] = !(iss_en && int'(iss_addr) == a);
        else begin
          e.data[p] = mdl_reg[a];
          e.rdy[p]  = !mdl_pend[a];
        end
      end
    end
    e.cnt  = r ? '0 : CW'(pend_count());
    e.anyp = (e.cnt != 0);
    e.tag  = tag;
    exp_q.push_back(e);
    pushed++;
    @(posedge clk);
    if (r) model_clear();
    else begin
      for (int w = 0; w < NWR; w++)
        if (wr_en[w] && wr_addr[w] != 0) begin
          mdl_reg[int'(wr_addr[w])]  = wr_data[w];
          mdl_pend[int'(wr_addr[w])] = 1'b0;
        end
      if (iss_en && iss_addr != 0) mdl_pend[int'(iss_addr)] = 1'b1;
    end
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      popped++;
      for (int p = 0; p < NRD; p++) begin
        checks++;
        if (rd_data[p] !== e.data[p]) begin
          errors++;
          $display("FAIL tag%0d rd_data[%0d] addr=%0d got=%h exp=%h", e.tag, p, rd_addr[p], rd_data[p], e.data[p]);
        end
        checks++;
        if (rd_ready[p] !== e.rdy[p]) begin
          errors++;
          $display("FAIL tag%0d rd_ready[%0d] addr=%0d got=%b exp=%b", e.tag, p, rd_addr[p], rd_ready[p], e.rdy[p]);
        end
      end
      checks++;
      if (pend_cnt !== e.cnt) begin
        errors++;
        $display("FAIL tag%0d pend_cnt got=%0d exp=%0d", e.tag, pend_cnt, e.cnt);
      end
      checks++;
      if (any_pend !== e.anyp) begin
        errors++;
        $display("FAIL tag%0d any_pend got=%b exp=%b", e.tag, any_pend, e.anyp);
      end
    end
  end

  initial begin
    rst = 1'b1;
    rd_addr = '0;
    idle();
    model_clear();
    @(posedge clk); #1;

    // Activity under reset is discarded.
    for (int i = 0; i < 2; i++) begin
      wr_en = '1; wr_addr[0] = 5'd6; wr_addr[1] = 5'd8; iss_en = 1'b1; iss_addr = 5'd6;
      rd_addr[0] = 5'd6; rd_addr[1] = 5'd8;
      step(1'b1, 1);
    end
    idle(); rd_addr[0] = 5'd6; rd_addr[1] = 5'd8; step(1'b0, 2);

    idle(); wr_en[0] = 1'b1; wr_addr[0] = 5'd5; wr_data[0] = 32'hDEADBEEF; step(1'b0, 10);
    idle(); rd_addr[0] = 5'd5; rd_addr[1] = 5'd0; step(1'b0, 11);

    idle(); wr_en[0] = 1'b1; wr_addr[0] = 5'd7; wr_data[0] = 32'h1234; rd_addr[1] = 5'd7; step(1'b0, 20);

    idle(); iss_en = 1'b1; iss_addr = 5'd3; step(1'b0, 30);
    idle(); rd_addr[0] = 5'd3; step(1'b0, 31);
    idle(); wr_en[1] = 1'b1; wr_addr[1] = 5'd3; wr_data[1] = 32'h55; rd_addr[0] = 5'd3; step(1'b0, 32);
    idle(); rd_addr[0] = 5'd3; step(1'b0, 33);

    idle(); iss_en = 1'b1; iss_addr = 5'd4; wr_en[0] = 1'b1; wr_addr[0] = 5'd4; wr_data[0] = 32'h9;
    rd_addr[1] = 5'd4; step(1'b0, 40);
    idle(); rd_addr[0] = 5'd4; step(1'b0, 41);

    idle(); wr_en = '1; wr_addr[0] = 5'd9; wr_addr[1] = 5'd9; wr_data[0] = 32'hA; wr_data[1] = 32'hB;
    rd_addr[0] = 5'd9; step(1'b0, 50);
    idle(); rd_addr[1] = 5'd9; wr_en[0] = 1'b1; wr_addr[0] = 5'd0; wr_data[0] = 32'hFF; rd_addr[0] = 5'd0;
    step(1'b0, 51);
    idle(); rd_addr[0] = 5'd0; rd_addr[1] = 5'd9; step(1'b0, 52);

    for (int i = 0; i < 400; i++) begin
      for (int p = 0; p < NRD; p++) rd_addr[p] = AW'($urandom_range(0, 7));
      for (int w = 0; w < NWR; w++) begin
        wr_en[w]   = ($urandom_range(0, 2) == 0);
        wr_addr[w] = AW'($urandom_range(0, 7));
        wr_data[w] = $urandom;
      end
      iss_en   = ($urandom_range(0, 2) == 0);
      iss_addr = AW'($urandom_range(0, 7));
      step($urandom_range(0, 99) == 0, 100);
    end

    for (int i = 1; i < NREG; i++) begin
      idle(); iss_en = 1'b1; iss_addr = AW'(i); rd_addr[0] = AW'(i); rd_addr[1] = AW'(NREG - i);
      step(1'b0, 200);
    end
    idle(); rd_addr[0] = 5'd17; rd_addr[1] = 5'd31; step(1'b0, 201);
    idle(); rd_addr[0] = 5'd5; rd_addr[1] = 5'd9; step(1'b1, 202);
    idle(); rd_addr[0] = 5'd4; rd_addr[1] = 5'd7; step(1'b0, 203);
    idle(); rd_addr[0] = 5'd3; rd_addr[1] = 5'd9; step(1'b0, 204);

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0 || popped != pushed) begin
      errors++;
      $display("FAIL drain got=%0d popped exp=%0d", popped, pushed);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
